// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and constants for the sprite DMA engine
package dma_pkg;

    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_HALT,
        DMA_ALIGN,
        DMA_READ,
        DMA_WRITE
    } dma_state_t;

    localparam logic [15:0] DMA_REG_ADDR = 16'h4014;
    localparam logic [2:0]  OAM_DATA_REG = 3'd4;

endpackage

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - $4014 sprite DMA: halts the CPU and copies one 256-byte page into OAM
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR = dma_pkg::DMA_REG_ADDR,
    parameter logic [2:0]  OAM_DATA_REG = dma_pkg::OAM_DATA_REG
) (
    input  logic        I_clock,
    input  logic        I_reset,
    input  logic        I_cpu_tick,
    input  logic [15:0] I_cpu_addr,
    input  logic        I_cpu_wren,
    input  logic [7:0]  I_cpu_data,
    input  logic        I_cpu_halted,
    output logic        O_cpu_halt,
    output logic        O_busy,
    output logic [15:0] O_dma_addr,
    output logic        O_dma_rden,
    input  logic [7:0]  I_dma_data,
    output logic [2:0]  O_ppu_addr,
    output logic        O_ppu_wren,
    output logic [7:0]  O_ppu_data
);

    import dma_pkg::*;

    dma_state_t state;
    dma_state_t state_n;
    logic       put;
    logic [7:0] page;
    logic [7:0] index;
    logic [7:0] index_n;
    logic [7:0] data;
    logic       trigger;

    assign trigger = I_cpu_wren && (I_cpu_addr == DMA_REG_ADDR);

    // Index as it will be after this tick, so the next read address is ready on entry to READ.
    assign index_n = (state == DMA_WRITE) ? index + 8'd1 : index;

    always_comb begin
        state_n = state;
        case (state)
            DMA_IDLE:  if (trigger) state_n = DMA_HALT;
            DMA_HALT:  if (I_cpu_halted) state_n = put ? DMA_READ : DMA_ALIGN;
            DMA_ALIGN: state_n = DMA_READ;
            DMA_READ:  state_n = DMA_WRITE;
            DMA_WRITE: state_n = (index == 8'hFF) ? DMA_IDLE : DMA_READ;
            default:   state_n = DMA_IDLE;
        endcase
    end

    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            state <= DMA_IDLE;
        end else if (I_cpu_tick) begin
            state <= state_n;
        end
    end

    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            put        <= 1'b0;
            page       <= 8'h00;
            index      <= 8'h00;
            data       <= 8'h00;
            O_cpu_halt <= 1'b0;
            O_busy     <= 1'b0;
            O_dma_rden <= 1'b0;
            O_dma_addr <= 16'h0000;
        end else if (I_cpu_tick) begin
            put        <= ~put;
            index      <= index_n;
            O_cpu_halt <= (state_n != DMA_IDLE);
            O_busy     <= (state_n != DMA_IDLE);
            O_dma_rden <= (state_n == DMA_READ);
            O_dma_addr <= (state_n == DMA_READ) ? {page, index_n} : 16'h0000;
            if (state == DMA_IDLE && trigger) begin
                page  <= I_cpu_data;
                index <= 8'h00;
            end
            if (state == DMA_READ) begin
                data <= I_dma_data;
            end
        end
    end

    // The host port writes on every clock wren is high, so the strobe is gated by the tick itself.
    assign O_ppu_wren = (state == DMA_WRITE) && I_cpu_tick;
    assign O_ppu_data = data;
    assign O_ppu_addr = OAM_DATA_REG;

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - directed self-checking bench for oam_dma
module tb_oam_dma;

    logic        I_clock = 1'b0;
    logic        I_reset = 1'b1;
    logic        I_cpu_tick = 1'b0;
    logic [15:0] I_cpu_addr = 16'h0000;
    logic        I_cpu_wren = 1'b0;
    logic [7:0]  I_cpu_data = 8'h00;
    logic        I_cpu_halted = 1'b1;
    logic        O_cpu_halt;
    logic        O_busy;
    logic [15:0] O_dma_addr;
    logic        O_dma_rden;
    logic [7:0]  I_dma_data;
    logic [2:0]  O_ppu_addr;
    logic        O_ppu_wren;
    logic [7:0]  O_ppu_data;

    int checks = 0;
    int errors = 0;

    int   wr_cnt = 0;
    int   exp_idx = 0;
    int   busy_ticks = 0;
    int   data_err = 0;
    int   width_err = 0;
    int   addr_err = 0;
    int   parity_err = 0;
    int   wait_rd_err = 0;
    logic bparity = 1'b0;
    logic prev_wren = 1'b0;

    oam_dma dut (
        .I_clock      (I_clock),
        .I_reset      (I_reset),
        .I_cpu_tick   (I_cpu_tick),
        .I_cpu_addr   (I_cpu_addr),
        .I_cpu_wren   (I_cpu_wren),
        .I_cpu_data   (I_cpu_data),
        .I_cpu_halted (I_cpu_halted),
        .O_cpu_halt   (O_cpu_halt),
        .O_busy       (O_busy),
        .O_dma_addr   (O_dma_addr),
        .O_dma_rden   (O_dma_rden),
        .I_dma_data   (I_dma_data),
        .O_ppu_addr   (O_ppu_addr),
        .O_ppu_wren   (O_ppu_wren),
        .O_ppu_data   (O_ppu_data)
    );

    always #5 I_clock = ~I_clock;

    // Page $02 holds i^A5; other pages differ, so a corrupted page shows up as bad data.
    assign I_dma_data = O_dma_rden ? (O_dma_addr[7:0] ^ 8'hA5 ^ O_dma_addr[15:8] ^ 8'h02) : 8'h00;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge I_clock) begin
        #1;
        if (I_reset) begin
            bparity   = 1'b0;
            prev_wren = 1'b0;
        end else begin
            if (O_ppu_addr != 3'd4) addr_err++;
            if (O_ppu_wren) begin
                if (prev_wren) width_err++;
                if (!bparity) parity_err++;
                if (O_ppu_data != 8'(exp_idx ^ 8'hA5)) data_err++;
                exp_idx++;
                wr_cnt++;
            end
            prev_wren = O_ppu_wren;
            if (O_dma_rden && !I_cpu_halted) wait_rd_err++;
            if (I_cpu_tick) begin
                if (O_dma_rden && bparity) parity_err++;
                if (O_busy) busy_ticks++;
                bparity = ~bparity;
            end
        end
    end

    task automatic cycle(input logic wr, input logic [15:0] a, input logic [7:0] d);
        @(negedge I_clock);
        I_cpu_tick = 1'b1;
        I_cpu_wren = wr;
        I_cpu_addr = a;
        I_cpu_data = d;
        @(negedge I_clock);
        I_cpu_tick = 1'b0;
        I_cpu_wren = 1'b0;
        @(negedge I_clock);
    endtask

    task automatic xfer(input string tag, input logic trig_put, input int wait_ticks,
                        input logic intrude, input int abort_at, input int exp_ticks);
        int n;
        if (bparity != trig_put) cycle(1'b0, 16'h0000, 8'h00);
        wr_cnt = 0;
        exp_idx = 0;
        busy_ticks = 0;
        data_err = 0;
        I_cpu_halted = (wait_ticks == 0);
        cycle(1'b1, 16'h4014, 8'h02);
        check({tag, "_halt_rise"}, int'(O_cpu_halt), 1);
        for (int i = 0; i < wait_ticks; i++) cycle(1'b1, 16'h2003, 8'h11);
        I_cpu_halted = 1'b1;
        n = 0;
        while (O_busy && n < 700 && !(abort_at > 0 && wr_cnt >= abort_at)) begin
            cycle(intrude && n == 50, 16'h4014, 8'h07);
            n++;
        end
        check({tag, "_timeout"}, int'(n < 700), 1);
        check({tag, "_data"}, data_err, 0);
        if (abort_at == 0) begin
            check({tag, "_count"}, wr_cnt, 256);
            check({tag, "_busy_ticks"}, busy_ticks, exp_ticks);
            check({tag, "_halt_drop"}, int'(O_cpu_halt), 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge I_clock);
        I_reset = 1'b0;
        #1;
        check("rst_halt", int'(O_cpu_halt), 0);
        check("rst_busy", int'(O_busy), 0);
        check("rst_rden", int'(O_dma_rden), 0);
        check("rst_daddr", int'(O_dma_addr), 0);
        check("rst_wren", int'(O_ppu_wren), 0);
        check("rst_pdata", int'(O_ppu_data), 0);
        check("rst_paddr", int'(O_ppu_addr), 4);

        xfer("get_trig", 1'b0, 0, 1'b0, 0, 513);
        xfer("put_trig", 1'b1, 0, 1'b0, 0, 514);
        xfer("halt_wait", 1'b0, 5, 1'b0, 0, 519);
        xfer("intrude", 1'b0, 0, 1'b1, 0, 513);

        xfer("abort", 1'b0, 0, 1'b0, 100, 0);
        check("abort_at", wr_cnt, 100);
        @(negedge I_clock);
        I_reset = 1'b1;
        @(negedge I_clock);
        I_reset = 1'b0;
        #1;
        check("abort_halt", int'(O_cpu_halt), 0);
        check("abort_busy", int'(O_busy), 0);
        repeat (20) cycle(1'b0, 16'h0000, 8'h00);
        check("abort_nowr", wr_cnt, 100);
        xfer("restart", 1'b0, 0, 1'b0, 0, 513);

        check("wren_width", width_err, 0);
        check("ppu_addr", addr_err, 0);
        check("parity", parity_err, 0);
        check("wait_read", wait_rd_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
